// File: rtl/alu_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Signed support is selected in the top by the macro ALU_MUL_SIGNED_EN.
package alu_mul_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam int unsigned MUL_ITER = 32;

    localparam logic [3:0] ALUCODE_ADDU = 4'b0000;
    localparam logic [3:0] ALUCODE_SUBU = 4'b0001;
    localparam logic [3:0] ALUCODE_AND  = 4'b0010;
    localparam logic [3:0] ALUCODE_OR   = 4'b0011;
    localparam logic [3:0] ALUCODE_XOR  = 4'b0100;

    // Two's-complement magnitude; -2^31 maps to 0x80000000 read as unsigned.
    function automatic logic [31:0] magnitude(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu_mul_seq_alu.sv
// Team 32-bit ALU; the multiplier only exercises ADDU and its carry-out.
module alu_mul_seq_alu
    import alu_mul_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluc,
    output logic [31:0] r,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;

    assign sum_s  = {1'b0, a} + {1'b0, b};
    assign diff_s = {1'b0, a} - {1'b0, b};

    // Operation select; carry is the add carry-out or the subtract borrow.
    always_comb begin
        r        = 32'd0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            ALUCODE_ADDU: begin
                r        = sum_s[31:0];
                carry    = sum_s[32];
                overflow = (a[31] == b[31]) && (sum_s[31] != a[31]);
            end
            ALUCODE_SUBU: begin
                r        = diff_s[31:0];
                carry    = diff_s[32];
                overflow = (a[31] != b[31]) && (diff_s[31] != a[31]);
            end
            ALUCODE_AND: r = a & b;
            ALUCODE_OR:  r = a | b;
            ALUCODE_XOR: r = a ^ b;
            default: begin
                r        = 32'd0;
                carry    = 1'b0;
                overflow = 1'b0;
            end
        endcase
    end

    assign zero     = (r == 32'd0);
    assign negative = r[31];

endmodule

// File: rtl/alu_mul_seq.sv
// 32x32 -> 64 sequential shift-add multiplier (MULTU, plus MULT when
// ALU_MUL_SIGNED_EN is defined). One product bit per CALC cycle.
module alu_mul_seq
    import alu_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

`ifdef ALU_MUL_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic        sgn_q, sgn_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        op_signed_s;
    logic [31:0] alu_sum_s;
    logic        alu_carry_s;
    logic        alu_zero_s, alu_neg_s, alu_ovf_s;
    logic        unused_s;

    assign op_signed_s = SIGNED_EN & is_signed;
    assign unused_s    = ^{alu_zero_s, alu_neg_s, alu_ovf_s};

    alu_mul_seq_alu u_alu (
        .a        (hi_q),
        .b        (mcand_q),
        .aluc     (ALUCODE_ADDU),
        .r        (alu_sum_s),
        .carry    (alu_carry_s),
        .zero     (alu_zero_s),
        .negative (alu_neg_s),
        .overflow (alu_ovf_s)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        sgn_d   = sgn_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = magnitude(a, op_signed_s);
                    lo_d    = magnitude(b, op_signed_s);
                    hi_d    = 32'd0;
                    cnt_d   = 6'd0;
                    neg_d   = op_signed_s & (a[31] ^ b[31]);
                    sgn_d   = op_signed_s;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                // The 65-bit {carry,sum,lo} shifted right by one drops lo[0].
                if (lo_q[0]) begin
                    hi_d = {alu_carry_s, alu_sum_s[31:1]};
                    lo_d = {alu_sum_s[0], lo_q[31:1]};
                end else begin
                    hi_d = {1'b0, hi_q[31:1]};
                    lo_d = {hi_q[0], lo_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MUL_ITER - 1)) begin
                    state_d = (SIGNED_EN && sgn_q) ? S_FIX : S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_FIX: begin
                if (neg_q) begin
                    {hi_d, lo_d} = ~{hi_q, lo_q} + 64'd1;
                end else begin
                    {hi_d, lo_d} = {hi_q, lo_q};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 6'd0;
            neg_q   <= 1'b0;
            sgn_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            sgn_q   <= sgn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed scenarios plus random operands
// checked against a plain 64-bit arithmetic product model.
module tb_alu_mul_seq;

`ifdef ALU_MUL_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    alu_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Reference product: sign-extend to 64 bits and multiply modulo 2^64.
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic s);
        logic [63:0] ex;
        logic [63:0] ey;
        if (SEN && s) begin
            ex = {{32{x[31]}}, x};
            ey = {{32{y[31]}}, y};
        end else begin
            ex = {32'd0, x};
            ey = {32'd0, y};
        end
        return ex * ey;
    endfunction

    function automatic int ref_lat(input logic s);
        return (SEN && s) ? 34 : 33;
    endfunction

    // One operation; optional stray start pulse with new operands in cycle inject.
    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                          input int inject, input string tag);
        logic [63:0] exp;
        logic [31:0] h_done;
        logic [31:0] l_done;
        int          lat;
        int          done_cyc;
        int          done_cnt;
        int          busy_bad;
        exp      = ref_prod(xa, xb, xs);
        lat      = ref_lat(xs);
        h_done   = 32'hxxxx_xxxx;
        l_done   = 32'hxxxx_xxxx;
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        @(negedge clk);
        a = xa; b = xb; is_signed = xs; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    h_done   = hi;
                    l_done   = lo;
                end
            end
            if (busy !== (cyc < lat)) busy_bad++;
            if (cyc == inject) begin
                start = 1'b1; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, " hi"}, 64'(h_done), 64'(exp[63:32]));
        chk({tag, " lo"}, 64'(l_done), 64'(exp[31:0]));
        chk({tag, " done_cycle"}, 64'(done_cyc), 64'(lat));
        chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, " busy_pattern_errs"}, 64'(busy_bad), 64'd0);
        chk({tag, " held"}, {hi, lo}, exp);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; is_signed = 1'b0; a = 32'd9; b = 32'd9;
        repeat (3) @(negedge clk);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        rst = 1'b0; start = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, 0, "3x5");
        chk("3x5 const", {hi, lo}, 64'h0000_0000_0000_000F);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "ffxff");
        chk("ffxff const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

        run_op(32'hFFFF_FFFE, 32'd3, 1'b1, 0, "m2x3");
        if (SEN) chk("m2x3 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        else     chk("m2x3 const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "min_sq");
        if (SEN) chk("min_sq const", {hi, lo}, 64'h4000_0000_0000_0000);
        else     chk("min_sq const", {hi, lo}, 64'h4000_0000_0000_0000);

        run_op(32'h8000_0000, 32'd1, 1'b1, 0, "minx1");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0, "m1x1");
        run_op(32'd0, 32'hDEAD_BEEF, 1'b1, 0, "zero");

        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 10, "stray_start");

        // Reset in cycle 15 of CALC.
        @(negedge clk);
        a = 32'hCAFE_F00D; b = 32'h0000_0123; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) @(negedge clk);
        chk("mid busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst hilo", {hi, lo}, 64'd0);
        run_op(32'd7, 32'd6, 1'b0, 0, "7x6");
        chk("7x6 const", 64'(lo), 64'h0000_002A);

        for (int i = 0; i < 10; i++) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = MULT (signed), 0 = MULTU; sampled with start.
REQ-006 a  input  32  multiplicand; sampled with start.
REQ-007 b  input  32  multiplier; sampled with start.
REQ-008 busy  output  1  high in CALC and FIX.
REQ-009 done  output  1  one-cycle pulse in DONE.
REQ-010 hi  output  32  upper product word, registered.
REQ-011 lo  output  32  lower product word, registered.

Function
REQ-012 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-013 In IDLE, start=1 SHALL latch the multiplicand magnitude into an internal register, set lo to the multiplier magnitude, clear hi, clear the 6-bit iteration counter, and move to CALC.
  - Magnitude: two's-complement negation when is_signed=1 and bit 31=1; the operand unchanged otherwise.
  - The XOR of the operand signs SHALL be stored as neg_flag.
REQ-014 Each CALC cycle SHALL perform one shift-add step.
  - lo[0]=1: {hi,lo} <= {carry,sum,lo[31:1]} >> 0, where {carry,sum} = hi + multiplicand from the ALU instance with aluc=ADDU.
  - lo[0]=0: {hi,lo} <= {1'b0,hi,lo[31:1]}.
REQ-015 The FSM SHALL leave CALC after exactly 32 steps (counter 31), and go to FIX if the signed feature is compiled in and is_signed was latched as 1, else to DONE.
REQ-016 FIX SHALL take one cycle: it replaces {hi,lo} with its 64-bit two's-complement negation when neg_flag=1, leaves it unchanged otherwise, and then goes to DONE.
REQ-017 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-018 hi and lo SHALL hold the final product from DONE until the next accepted start.
REQ-019 Latency: counting the cycle in which start is accepted as cycle 0, done SHALL be high in cycle 33 (unsigned) or cycle 34 (signed).
REQ-020 start in CALC, FIX or DONE SHALL be ignored with no effect on state or outputs.
REQ-021 Changes on a, b and is_signed after acceptance SHALL have no effect on the result in progress.
REQ-022 Operand -2^31 SHALL have a magnitude of 0x80000000, treated as unsigned, and SHALL produce the correct product.

Reset
REQ-023 rst=1 SHALL force IDLE and set busy=0, done=0, hi=0, lo=0, the counter to 0 and neg_flag to 0 at the next edge, from any state including mid-CALC.
REQ-024 rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 With the macro ALU_MUL_SIGNED_EN defined, signed handling SHALL be compiled in: magnitude conversion, neg_flag, and the FIX state.
REQ-026 Without ALU_MUL_SIGNED_EN, is_signed SHALL be ignored, every operation SHALL be MULTU, FIX SHALL be unreachable, and latency SHALL always be 33.

Structure
REQ-027 Package alu_mul_pkg SHALL hold the following:
  - the state encoding typedef;
  - the constant MUL_ITER=32;
  - the ALU operation constant ALUCODE_ADDU=4'b0000.
REQ-028 Exactly one sub-module SHALL be instantiated: the team's ALU, which provides the 32-bit add and its carry for each CALC step.
  - Its a input is driven by hi, b by the multiplicand register, and aluc by ALUCODE_ADDU.
  - Its zero, negative and overflow outputs are unused.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
  - a=3, b=5, is_signed=0 -> hi=0x00000000, lo=0x0000000F, done high in cycle 33, busy high in cycles 1..32.
  - a=b=0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001.
  - a=0xFFFFFFFE (-2), b=3, is_signed=1 -> macro on: hi=0xFFFFFFFF, lo=0xFFFFFFFA, done in cycle 34; macro off: hi=0x00000002, lo=0xFFFFFFFA, done in cycle 33.
  - a=b=0x80000000, is_signed=1, macro on -> hi=0x40000000, lo=0x00000000.
  - start pulsed in cycle 10 with new operands during an operation -> the result matches the first operands and no second done occurs.
  - rst in cycle 15 of CALC -> busy=0, hi=lo=0 next cycle; then a=7, b=6 -> lo=0x0000002A.
